// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Divides the system clock by two to form the pixel clock and scans
// DrawX/DrawY across the frame. It also decodes sync and blank from the
// counter position and can delay those decodes by a few pixel ticks so
// they line up with a pipelined RGB path downstream.
module vga_timing_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int PIPE_DELAY      = 0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       VGA_CLK,
    output logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_start,
    output logic       line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic SYNC_INV = (SYNC_ACTIVE_LOW != 0);

    // A zero-length delay still gets one stage so the pipe array always
    // has a legal shape; the stage is bypassed by the output select.
    localparam int PD_W = (PIPE_DELAY > 0) ? PIPE_DELAY : 1;

    logic       toggle_q, toggle_d;
    logic [9:0] drawx_q, drawx_d;
    logic [9:0] drawy_q, drawy_d;
    logic       hs_act_q, hs_act_d;
    logic       vs_act_q, vs_act_d;
    logic       blank_n_q, blank_n_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    // Each pipe stage holds {hs_active, vs_active, blank_n}.
    logic [PD_W-1:0][2:0] pipe_q, pipe_d;
    logic [2:0]           sync_sel;

    logic x_wrap;
    logic y_wrap;

    assign x_wrap = (drawx_q == H_MAX);
    assign y_wrap = (drawy_q == V_MAX);

    // The pixel tick falls on every second system clock, while the divider is high.
    assign pix_en = toggle_q;

    // Divider toggle: flips every system clock.
    always_comb begin
        toggle_d = ~toggle_q;
    end

    // Scan counters: X always advances on a pixel tick, Y only on the X wrap.
    always_comb begin
        drawx_d = drawx_q;
        drawy_d = drawy_q;
        if (pix_en) begin
            drawx_d = x_wrap ? 10'd0 : drawx_q + 10'd1;
            if (x_wrap) begin
                drawy_d = y_wrap ? 10'd0 : drawy_q + 10'd1;
            end
        end
    end

    // Sync and blank are decoded from the next position so that they share a clock edge with the counters.
    always_comb begin
        hs_act_d  = hs_act_q;
        vs_act_d  = vs_act_q;
        blank_n_d = blank_n_q;
        if (pix_en) begin
            hs_act_d  = (drawx_d >= HS_FIRST) && (drawx_d <= HS_LAST);
            vs_act_d  = (drawy_d >= VS_FIRST) && (drawy_d <= VS_LAST);
            blank_n_d = (drawx_d < H_VIS) && (drawy_d < V_VIS);
        end
    end

    // Start pulses: high for the single clock that follows the wrap tick.
    always_comb begin
        line_start_d  = pix_en && x_wrap;
        frame_start_d = pix_en && x_wrap && y_wrap;
    end

    // Delay pipe: a shift register that moves only on pixel ticks.
    always_comb begin
        pipe_d = pipe_q;
        if (pix_en) begin
            pipe_d[0] = {hs_act_q, vs_act_q, blank_n_q};
            for (int i = 1; i < PD_W; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    // State registers. Reset clears every stage to inactive sync and blanked video.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            toggle_q      <= 1'b0;
            drawx_q       <= 10'd0;
            drawy_q       <= 10'd0;
            hs_act_q      <= 1'b0;
            vs_act_q      <= 1'b0;
            blank_n_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pipe_q        <= '0;
        end else begin
            toggle_q      <= toggle_d;
            drawx_q       <= drawx_d;
            drawy_q       <= drawy_d;
            hs_act_q      <= hs_act_d;
            vs_act_q      <= vs_act_d;
            blank_n_q     <= blank_n_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            pipe_q        <= pipe_d;
        end
    end

    assign sync_sel = (PIPE_DELAY == 0) ? {hs_act_q, vs_act_q, blank_n_q}
                                        : pipe_q[PD_W-1];

    assign VGA_CLK     = toggle_q;
    assign DrawX       = drawx_q;
    assign DrawY       = drawy_q;
    assign VGA_HS      = sync_sel[2] ^ SYNC_INV;
    assign VGA_VS      = sync_sel[1] ^ SYNC_INV;
    assign VGA_BLANK_N = sync_sel[0];
    assign VGA_SYNC_N  = 1'b0;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, a small
// active-low raster, a small active-high raster with a 2-tick delay).
// The reference model derives every output from the number of clocks
// since reset release using plain division and modulo arithmetic.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #10 Clk = ~Clk;

    typedef struct packed {
        logic       vclk;
        logic       pix;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       sn;
        logic       fs;
        logic       ls;
    } obs_t;

    logic       a_vclk, a_pix, a_hs, a_vs, a_bn, a_sn, a_fs, a_ls;
    logic [9:0] a_x, a_y;
    logic       b_vclk, b_pix, b_hs, b_vs, b_bn, b_sn, b_fs, b_ls;
    logic [9:0] b_x, b_y;
    logic       c_vclk, c_pix, c_hs, c_vs, c_bn, c_sn, c_fs, c_ls;
    logic [9:0] c_x, c_y;

    obs_t oa, ob, oc;
    assign oa = {a_vclk, a_pix, a_x, a_y, a_hs, a_vs, a_bn, a_sn, a_fs, a_ls};
    assign ob = {b_vclk, b_pix, b_x, b_y, b_hs, b_vs, b_bn, b_sn, b_fs, b_ls};
    assign oc = {c_vclk, c_pix, c_x, c_y, c_hs, c_vs, c_bn, c_sn, c_fs, c_ls};

    vga_timing_gen dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(a_vclk), .pix_en(a_pix),
        .DrawX(a_x), .DrawY(a_y), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn), .frame_start(a_fs), .line_start(a_ls)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_ACTIVE_LOW(1), .PIPE_DELAY(0)
    ) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(b_vclk), .pix_en(b_pix),
        .DrawX(b_x), .DrawY(b_y), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn), .frame_start(b_fs), .line_start(b_ls)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_ACTIVE_LOW(0), .PIPE_DELAY(2)
    ) dut_c (
        .Clk(Clk), .Reset_n(Reset_n), .VGA_CLK(c_vclk), .pix_en(c_pix),
        .DrawX(c_x), .DrawY(c_y), .VGA_HS(c_hs), .VGA_VS(c_vs),
        .VGA_BLANK_N(c_bn), .VGA_SYNC_N(c_sn), .frame_start(c_fs), .line_start(c_ls)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;   // rising clock edges since reset release

    // Expected outputs after c clocks out of reset. Pixel ticks land on even clock counts.
    // The sync/blank outputs show the position pd ticks earlier. Before the first tick
    // has filled that stage, they keep their reset values.
    function automatic obs_t model(input int ha, input int hf, input int hw, input int hb,
                                   input int va, input int vf, input int vw, input int vb,
                                   input int sal, input int pd, input int c);
        obs_t m;
        int   ht, vt, n, p, px, py;
        bit   hact, vact, bn, ticked;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        n  = c / 2;
        p  = n - pd;
        hact = 1'b0;
        vact = 1'b0;
        bn   = 1'b0;
        if (p >= 1) begin
            px   = p % ht;
            py   = (p / ht) % vt;
            hact = (px >= ha + hf) && (px < ha + hf + hw);
            vact = (py >= va + vf) && (py < va + vf + vw);
            bn   = (px < ha) && (py < va);
        end
        ticked = (c > 0) && (c % 2 == 0);
        m.vclk = logic'(c % 2);
        m.pix  = logic'(c % 2);
        m.x    = 10'(n % ht);
        m.y    = 10'((n / ht) % vt);
        m.hs   = hact ^ (sal != 0);
        m.vs   = vact ^ (sal != 0);
        m.bn   = bn;
        m.sn   = 1'b0;
        m.ls   = ticked && (n % ht == 0);
        m.fs   = ticked && (n % (ht * vt) == 0);
        return m;
    endfunction

    task automatic chk(input string tag, input obs_t o, input obs_t e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d got clk=%b pix=%b x=%0d y=%0d hs=%b vs=%b bn=%b sn=%b fs=%b ls=%b exp clk=%b pix=%b x=%0d y=%0d hs=%b vs=%b bn=%b sn=%b fs=%b ls=%b",
                   tag, cyc, o.vclk, o.pix, o.x, o.y, o.hs, o.vs, o.bn, o.sn, o.fs, o.ls,
                   e.vclk, e.pix, e.x, e.y, e.hs, e.vs, e.bn, e.sn, e.fs, e.ls);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_A"}, oa, model(640, 16, 96, 48, 480, 10, 2, 33, 1, 0, cyc));
        chk({tag, "_B"}, ob, model(16, 2, 4, 3, 6, 1, 2, 2, 1, 0, cyc));
        chk({tag, "_C"}, oc, model(16, 2, 4, 3, 6, 1, 2, 2, 0, 2, cyc));
    endtask

    // One clock of scan, checked half a period after the edge.
    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
            check_all(tag);
        end
    endtask

    // Drop reset mid-cycle and confirm the clear before any clock edge.
    // Then hold reset for a few cycles and release it on a falling edge.
    task automatic reset_pulse(input int hold, input string tag);
        Reset_n = 1'b0;
        cyc = 0;
        #1;
        check_all({tag, "_async"});
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            check_all({tag, "_hold"});
        end
        Reset_n = 1'b1;
    endtask

    initial begin
        logic [19:0] xy_b;

        // Power-up reset, then several frames of the small rasters and two default lines.
        @(negedge Clk);
        reset_pulse(3, "por");
        run(3400, "scan");

        // Directed mid-frame reset while the small raster is inside both sync pulses.
        @(negedge Clk);
        reset_pulse(2, "pre_dir");
        run(438, "to_sync");
        xy_b = {b_x, b_y};
        n_cmp++;
        assert (xy_b === {10'd19, 10'd8}) else begin
            n_bad++;
            $error("FAIL B_xy_before_reset got x=%0d y=%0d exp x=19 y=8", b_x, b_y);
        end
        reset_pulse(2, "mid_sync");
        run(120, "resume");

        // Random reset points and hold lengths.
        for (int k = 0; k < 4; k++) begin
            run(int'($urandom_range(50, 1200)), "rnd_run");
            reset_pulse(int'($urandom_range(1, 3)), "rnd_rst");
        end
        run(600, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
